// File: rtl/fft8_pkg.sv
// Shared constants, state encoding and helpers for the 8-point FFT sequencer.
package fft8_pkg;

  localparam int N                   = 8;
  localparam int LOG2N               = 3;
  localparam int ROM_LATENCY_DEFAULT = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_GAP     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [1:0]       stage;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
  } bf_op_t;

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] v);
    return {v[0], v[1], v[2]};
  endfunction

endpackage

// File: rtl/fft8_align_pipe.sv
// Fixed-depth, never-stalled delay line that lines butterfly operands up with
// the twiddle ROM output.
module fft8_align_pipe
  import fft8_pkg::*;
#(
  parameter int DEPTH = ROM_LATENCY_DEFAULT
) (
  input  logic   clk,
  input  logic   rst,
  input  bf_op_t d_i,
  output bf_op_t q_o
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    bf_op_t op_q;
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (rst) op_q <= '0;
        else     op_q <= d_i;
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (rst) op_q <= '0;
        else     op_q <= g_stage[gi-1].op_q;
      end
    end
  end

  assign q_o = g_stage[DEPTH-1].op_q;

endmodule

// File: rtl/fft8_sequencer.sv
// Load / compute / drain controller for an 8-point radix-2 DIT FFT: bit-reversed
// load addresses, twiddle indices and ROM-aligned butterfly operand addresses.
module fft8_sequencer
  import fft8_pkg::*;
#(
  parameter int ROM_LATENCY  = ROM_LATENCY_DEFAULT,
  parameter int STAGE_GAP    = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ld_wr_en,
  output logic [LOG2N-1:0] ld_wr_addr,
  output logic [LOG2N-1:0] tw_index,
  output logic             bf_valid,
  output logic [1:0]       bf_stage,
  output logic [LOG2N-1:0] bf_addr_a,
  output logic [LOG2N-1:0] bf_addr_b,
  output logic             busy,
  output logic             done
);

  localparam logic [7:0] GAP_LAST   = 8'(STAGE_GAP - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [LOG2N-1:0] n_q, n_d;
  logic [1:0]       s_q, s_d;
  logic [1:0]       j_q, j_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             ld_wr_en_q, ld_wr_en_d;
  logic [LOG2N-1:0] ld_wr_addr_q, ld_wr_addr_d;
  logic [LOG2N-1:0] tw_q, tw_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  bf_op_t           issue_q, issue_d;
  bf_op_t           pipe_out;

  logic [LOG2N-1:0] span, k, g, addr_a, addr_b, tw;

  // Butterfly j of stage s: pairs are span apart, grouped in blocks of 2*span.
  always_comb begin
    span   = 3'd1 << s_q;
    k      = {1'b0, j_q} & (span - 3'd1);
    g      = {1'b0, j_q} >> s_q;
    addr_a = (g << (s_q + 2'd1)) + k;
    addr_b = addr_a + span;
    tw     = k << (2'd2 - s_q);
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    s_d          = s_q;
    j_d          = j_q;
    cnt_d        = cnt_q;
    ld_wr_en_d   = 1'b0;
    ld_wr_addr_d = ld_wr_addr_q;
    tw_d         = tw_q;
    issue_d      = '0;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        n_d = '0;
        // done_q marks the first IDLE cycle; a start there belongs to the old run.
        if (start && !done_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (in_valid) begin
          ld_wr_en_d   = 1'b1;
          ld_wr_addr_d = bitrev3(n_q);
          n_d          = n_q + 3'd1;
          if (n_q == 3'd7) begin
            state_d = ST_COMPUTE;
            s_d     = '0;
            j_d     = '0;
          end
        end
      end
      ST_COMPUTE: begin
        tw_d           = tw;
        issue_d.valid  = 1'b1;
        issue_d.stage  = s_q;
        issue_d.addr_a = addr_a;
        issue_d.addr_b = addr_b;
        j_d            = j_q + 2'd1;
        if (j_q == 2'd3) begin
          cnt_d   = '0;
          state_d = (s_q == 2'd2) ? ST_DRAIN : ST_GAP;
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == GAP_LAST) begin
          s_d     = s_q + 2'd1;
          j_d     = '0;
          state_d = ST_COMPUTE;
        end
      end
      ST_DRAIN: begin
        // cnt tracks cycles since the most recent bf_valid on the outputs.
        if (pipe_out.valid) begin
          cnt_d = 8'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == DRAIN_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_LOAD);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      s_q          <= '0;
      j_q          <= '0;
      cnt_q        <= '0;
      in_ready_q   <= 1'b0;
      ld_wr_en_q   <= 1'b0;
      ld_wr_addr_q <= '0;
      tw_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      issue_q      <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      s_q          <= s_d;
      j_q          <= j_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      ld_wr_en_q   <= ld_wr_en_d;
      ld_wr_addr_q <= ld_wr_addr_d;
      tw_q         <= tw_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      issue_q      <= issue_d;
    end
  end

  // issue_q moves with tw_index; the pipe adds the ROM's own latency.
  fft8_align_pipe #(
    .DEPTH (ROM_LATENCY)
  ) u_align (
    .clk (clk),
    .rst (rst),
    .d_i (issue_q),
    .q_o (pipe_out)
  );

  assign in_ready   = in_ready_q;
  assign ld_wr_en   = ld_wr_en_q;
  assign ld_wr_addr = ld_wr_addr_q;
  assign tw_index   = tw_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bf_valid   = pipe_out.valid;
  assign bf_stage   = pipe_out.stage;
  assign bf_addr_a  = pipe_out.addr_a;
  assign bf_addr_b  = pipe_out.addr_b;

endmodule

// File: tb/tb_fft8_sequencer.sv
// Scoreboard bench for fft8_sequencer with an fp16 twiddle ROM model attached.
module tb_fft8_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready, ld_wr_en, bf_valid, busy, done;
  logic [2:0] ld_wr_addr, tw_index, bf_addr_a, bf_addr_b;
  logic [1:0] bf_stage;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int beat_cyc = 0;

  typedef struct {
    int stage;
    int a;
    int b;
    int wr;
    int wi;
  } bf_exp_t;

  logic [2:0] exp_ld[$];
  bf_exp_t    exp_bf[$];
  int         ld_cyc_q[$];
  int         bf_cyc_q[$];

  int a_tab  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int b_tab  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int tw_tab [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  fft8_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ld_wr_en   (ld_wr_en),
    .ld_wr_addr (ld_wr_addr),
    .tw_index   (tw_index),
    .bf_valid   (bf_valid),
    .bf_stage   (bf_stage),
    .bf_addr_a  (bf_addr_a),
    .bf_addr_b  (bf_addr_b),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // fp16 twiddles W8^k = cos(2*pi*k/8) - j*sin(2*pi*k/8)
  function automatic logic [15:0] rom_re(input logic [2:0] i);
    case (i)
      3'd0: return 16'h3c00;
      3'd1: return 16'h39a8;
      3'd2: return 16'h0000;
      3'd3: return 16'hb9a8;
      3'd4: return 16'hbc00;
      3'd5: return 16'hb9a8;
      3'd6: return 16'h0000;
      default: return 16'h39a8;
    endcase
  endfunction

  function automatic logic [15:0] rom_im(input logic [2:0] i);
    case (i)
      3'd0: return 16'h0000;
      3'd1: return 16'hb9a8;
      3'd2: return 16'hbc00;
      3'd3: return 16'hb9a8;
      3'd4: return 16'h0000;
      3'd5: return 16'h39a8;
      3'd6: return 16'h3c00;
      default: return 16'h39a8;
    endcase
  endfunction

  logic [2:0] rom1 = 3'd0;
  logic [2:0] rom2 = 3'd0;
  always @(posedge clk) begin
    rom1 <= tw_index;
    rom2 <= rom1;
  end

  logic [2:0] ld_e;
  bf_exp_t    bf_e;

  always @(negedge clk) begin
    if (ld_wr_en) begin
      compared++;
      ld_cyc_q.push_back(cyc);
      if (exp_ld.size() == 0) begin
        mismatched++;
        $display("FAIL ld_unexpected: cyc %0d got write addr %0d, required no write", cyc, ld_wr_addr);
      end else begin
        ld_e = exp_ld.pop_front();
        if (ld_wr_addr !== ld_e) begin
          mismatched++;
          $display("FAIL ld_addr: cyc %0d got %0d, required %0d", cyc, ld_wr_addr, ld_e);
        end
      end
      $display("LD cyc=%0d addr=%0d", cyc, ld_wr_addr);
    end
    if (bf_valid) begin
      compared++;
      bf_cyc_q.push_back(cyc);
      if (exp_bf.size() == 0) begin
        mismatched++;
        $display("FAIL bf_unexpected: cyc %0d got s%0d a%0d b%0d, required no butterfly",
                 cyc, bf_stage, bf_addr_a, bf_addr_b);
      end else begin
        bf_e = exp_bf.pop_front();
        if (int'(bf_stage) != bf_e.stage || int'(bf_addr_a) != bf_e.a || int'(bf_addr_b) != bf_e.b ||
            int'(rom_re(rom2)) != bf_e.wr || int'(rom_im(rom2)) != bf_e.wi) begin
          mismatched++;
          $display("FAIL bf_tuple: cyc %0d got s%0d a%0d b%0d W=%h/%h, required s%0d a%0d b%0d W=%h/%h",
                   cyc, bf_stage, bf_addr_a, bf_addr_b, rom_re(rom2), rom_im(rom2),
                   bf_e.stage, bf_e.a, bf_e.b, 16'(bf_e.wr), 16'(bf_e.wi));
        end
      end
      $display("BF cyc=%0d s=%0d a=%0d b=%0d W=%h/%h", cyc, bf_stage, bf_addr_a, bf_addr_b,
               rom_re(rom2), rom_im(rom2));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_transform();
    bf_exp_t e;
    for (int i = 0; i < 12; i++) begin
      e.stage = i / 4;
      e.a     = a_tab[i];
      e.b     = b_tab[i];
      e.wr    = int'(rom_re(3'(tw_tab[i])));
      e.wi    = int'(rom_im(3'(tw_tab[i])));
      exp_bf.push_back(e);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    compared++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL start_accept: got in_ready=%b busy=%b, required 1/1", in_ready, busy);
    end
  endtask

  task automatic load(input int gap, input bit start_noise);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] n;
      n = 3'(i);
      exp_ld.push_back({n[0], n[1], n[2]});
      in_valid = 1'b1;
      start    = start_noise;
      beat_cyc = cyc;
      step();
      in_valid = 1'b0;
      start    = 1'b0;
      if (i == 7) begin
        compared++;
        if (in_ready !== 1'b0) begin
          mismatched++;
          $display("FAIL in_ready_fall: got %b after 8th beat, required 0", in_ready);
        end
      end else begin
        repeat (gap) step();
      end
    end
  endtask

  task automatic wait_done(input bit noise, input bit start_on_done, output int done_c);
    done_c = -1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (done === 1'b1) begin
        done_c = cyc;
        break;
      end
      if (noise) in_valid = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    compared++;
    if (done_c < 0) begin
      mismatched++;
      $display("FAIL done_timeout: got no done within 300 cycles, required a done pulse");
      return;
    end
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL busy_at_done: got busy=%b, required 0", busy);
    end
    start = start_on_done;
    step();
    start = 1'b0;
    compared++;
    if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL after_done: got done=%b busy=%b in_ready=%b, required 0/0/0", done, busy, in_ready);
    end
    step();
    compared++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL start_on_done: got busy=%b in_ready=%b, required 0/0", busy, in_ready);
    end
  endtask

  task automatic run_transform(input int gap, input bit start_noise, input bit noise,
                               input bit start_on_done);
    int done_c;
    bit bad;
    ld_cyc_q.delete();
    bf_cyc_q.delete();
    push_transform();
    do_start();
    load(gap, start_noise);
    wait_done(noise, start_on_done, done_c);

    compared++;
    if (ld_cyc_q.size() != 8 || (ld_cyc_q[ld_cyc_q.size()-1] - ld_cyc_q[0]) != 7 * (gap + 1)) begin
      mismatched++;
      $display("FAIL ld_spacing: got %0d writes, required 8 spaced %0d apart", ld_cyc_q.size(), gap + 1);
    end
    compared++;
    if (bf_cyc_q.size() != 12) begin
      mismatched++;
      $display("FAIL bf_count: got %0d, required 12", bf_cyc_q.size());
    end else begin
      compared++;
      if (bf_cyc_q[0] != beat_cyc + 4) begin
        mismatched++;
        $display("FAIL bf_first: got cyc %0d, required %0d", bf_cyc_q[0], beat_cyc + 4);
      end
      bad = 1'b0;
      for (int i = 1; i < 12; i++)
        if (bf_cyc_q[i] - bf_cyc_q[i-1] != ((i == 4 || i == 8) ? 5 : 1)) bad = 1'b1;
      compared++;
      if (bad) begin
        mismatched++;
        $display("FAIL stage_gap: got bf spacing irregular (first %0d last %0d), required 4 idle cycles between stages",
                 bf_cyc_q[0], bf_cyc_q[11]);
      end
      compared++;
      if (done_c - bf_cyc_q[11] != 4) begin
        mismatched++;
        $display("FAIL drain_len: got done %0d cycles after last bf, required 4", done_c - bf_cyc_q[11]);
      end
    end
    compared++;
    if (exp_bf.size() != 0 || exp_ld.size() != 0) begin
      mismatched++;
      $display("FAIL leftover: got %0d bf / %0d ld expected items unconsumed, required 0/0",
               exp_bf.size(), exp_ld.size());
      exp_bf.delete();
      exp_ld.delete();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 3 == 0);
      step();
      compared++;
      if ({in_ready, ld_wr_en, busy, done, bf_valid, ld_wr_addr, tw_index, bf_stage, bf_addr_a, bf_addr_b} !== '0) begin
        mismatched++;
        $display("FAIL idle_outputs: cyc %0d got rdy=%b wr=%b busy=%b done=%b bfv=%b tw=%0d, required all 0",
                 cyc, in_ready, ld_wr_en, busy, done, bf_valid, tw_index);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_transform(0, 1'b0, 1'b0, 1'b1);
    run_transform(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_irregular_load();
    run_transform(2, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_rst_midcompute();
    int seen;
    push_transform();
    do_start();
    load(0, 1'b0);
    while (cyc < beat_cyc + 10) step();
    rst   = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    compared++;
    if (bf_valid !== 1'b0 || busy !== 1'b0 || tw_index !== 3'd0 || in_ready !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_clear: got bfv=%b busy=%b tw=%0d rdy=%b done=%b, required all 0",
               bf_valid, busy, tw_index, in_ready, done);
    end
    exp_bf.delete();
    rst  = 1'b0;
    seen = bf_cyc_q.size();
    repeat (12) step();
    compared++;
    if (bf_cyc_q.size() != seen || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_stale: got %0d stale bf_valid, busy=%b, required 0/0", bf_cyc_q.size() - seen, busy);
    end
    run_transform(0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    test_reset();
    test_back_to_back();
    test_irregular_load();
    test_rst_midcompute();
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fft8_sequencer.md
Name: fft8_sequencer

Overview:
- Control and address generator for the 8-point radix-2 DIT FFT.
- Runs a load phase: accepts 8 input samples and produces bit-reversed write addresses for the data store.
- Then walks 3 stages × 4 butterflies, driving the 3-bit twiddle index into the twiddle ROM.
- Emits butterfly operand addresses delayed to line up with the ROM's registered Wreal/Wimag outputs, so the downstream butterfly sees twiddle and addresses in the same cycle.

Parameters:
- ROM_LATENCY, 2: cycles from tw_index to valid Wreal/Wimag; the alignment delay applied to bf_* outputs.
- STAGE_GAP, 4: idle cycles inserted between stages; covers butterfly write-back before the next stage reads.
- DRAIN_CYCLES, 4: cycles after the last bf_valid before done pulses.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a transform; sampled only in IDLE.
- in_valid  in  1  input sample present this cycle.
- in_ready  out  1  high throughout LOAD.
- ld_wr_en  out  1  write strobe to the data store; equals in_valid & in_ready, registered.
- ld_wr_addr  out  3  bit-reversed load address, registered with ld_wr_en.
- tw_index  out  3  twiddle ROM index, registered.
- bf_valid  out  1  butterfly operation valid; aligned with ROM output.
- bf_stage  out  2  stage number 0..2, aligned.
- bf_addr_a  out  3  top operand address, aligned.
- bf_addr_b  out  3  bottom operand address, aligned.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of transform.

Behaviour:
- All outputs are registered; all reset to 0. State resets to IDLE; all counters and the alignment pipe reset to 0.
- States: IDLE, LOAD, COMPUTE, GAP, DRAIN.
- IDLE: start=1 → LOAD on the next cycle. in_valid is ignored in IDLE.
- LOAD:
  - in_ready=1. Each in_valid beat increments load count n (0..7).
  - One cycle after the beat: ld_wr_en=1 and ld_wr_addr={n[0],n[1],n[2]}.
  - After the 8th beat → COMPUTE with stage s=0, butterfly j=0.
  - No timeout; gaps between beats are allowed.
- COMPUTE: issues one butterfly per cycle, j = 0..3.
  - span = 1<<s; k = j & (span-1); g = j >> s.
  - a = g*2*span + k; b = a + span; tw_index (registered) = k << (2-s).
  - Operand tuple {s,a,b,valid=1} enters a ROM_LATENCY-deep delay pipe that is never stalled. bf_* appear exactly ROM_LATENCY cycles after the matching tw_index.
  - After j=3: if s<2 → GAP; else → DRAIN.
- GAP: counts STAGE_GAP cycles, increments s, → COMPUTE with j=0. tw_index holds its last value; no valid enters the pipe.
- DRAIN: the pipe continues to flush. After DRAIN_CYCLES counted from the last bf_valid, pulse done=1 for one cycle → IDLE. busy falls in the same cycle done rises.
- Required index sequence (s: tw; a/b):
  - s0: tw 0,0,0,0; a/b 0/1, 2/3, 4/5, 6/7.
  - s1: tw 0,2,0,2; a/b 0/2, 1/3, 4/6, 5/7.
  - s2: tw 0,1,2,3; a/b 0/4, 1/5, 2/6, 3/7.
- Boundary conditions:
  - start while busy: ignored.
  - start and rst together: rst wins.
  - rst in any state: next cycle is IDLE with all outputs 0. The pipe is cleared, so no stale bf_valid appears after reset.
  - in_valid outside LOAD: dropped; no ld_wr_en.
  - start asserted in the same cycle done pulses: ignored. A new start is accepted from the following IDLE cycle.
- Total COMPUTE+GAP length = 12 + 2*STAGE_GAP cycles. Exactly 12 bf_valid pulses per transform.

Decomposition:
- Shared package fft8_pkg:
  - N=8, LOG2N=3.
  - State encoding constants.
  - bitrev3 function.
  - Default ROM_LATENCY=2, which must match the twiddle ROM's latency.
- One sub-module fft8_align_pipe: parameterised-depth shift register for {valid, stage[1:0], addr_a[2:0], addr_b[2:0]} with synchronous clear on rst.
- Address arithmetic stays inline in the sequencer.

Test Plan:
- Reset release, no start → all outputs 0, busy=0 for 20 cycles; in_valid pulses produce no ld_wr_en.
- start, then 8 back-to-back in_valid → ld_wr_addr sequence 0,4,2,6,1,5,3,7 with ld_wr_en high for 8 consecutive cycles; in_ready falls after the 8th beat.
- Full transform with a ROM model attached → 12 bf_valid cycles matching the index table above. Each bf cycle carries the ROM value for the tw_index issued 2 cycles earlier (e.g. s2 j1: Wreal=0x39a8, Wimag=0xb9a8). Stages are separated by exactly STAGE_GAP=4 idle cycles.
- Timing: done pulses exactly DRAIN_CYCLES after the last bf_valid; busy=0 from that cycle; a second start then repeats the identical sequence.
- Irregular loads (in_valid on every third cycle) → same 8 bit-reversed addresses; COMPUTE starts one cycle after the 8th beat.
- rst asserted during stage-1 COMPUTE, with bf_valid pending in the pipe → the next cycle shows bf_valid=0, busy=0, tw_index=0, and no further bf_valid; start then runs a clean full transform.
